// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: memory bus constants, loader state encoding and word sizing helper
package mem_loader_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 64;

    localparam logic [1:0] MEM_FUNC_READ  = 2'd0;
    localparam logic [1:0] MEM_FUNC_WRITE = 2'd1;
    localparam logic [1:0] MEM_FUNC_INIT  = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_COLLECT,
        S_WRITE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DONE,
        S_ERROR
    } loader_state_t;

    function automatic int bytes_per_word(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/mem_loader_byte_packer.sv
// mem_loader_byte_packer: gathers little-endian bytes into one memory word
module mem_loader_byte_packer
    import mem_loader_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              take,
    input  logic [7:0]        byte_data,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);

    localparam int NB = bytes_per_word(DATA_W);
    localparam int IW = NB > 1 ? $clog2(NB) : 1;

    logic [NB*8-1:0] buf_q;
    logic [IW-1:0]   idx;
    logic            last;

    assign last       = idx == IW'(NB - 1);
    assign word_valid = take & last;
    assign word       = buf_q[DATA_W-1:0];

    // place each accepted byte in its lane; the index wraps after the last lane
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q <= '0;
            idx   <= '0;
        end else if (clear) begin
            buf_q <= '0;
            idx   <= '0;
        end else if (take) begin
            buf_q[{idx, 3'b000} +: 8] <= byte_data;
            idx                       <= last ? '0 : idx + IW'(1);
        end
    end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: receives a framed byte image, writes it to memory, then hands off to traversal
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int DATA_W    = MEM_DATA_W,
    parameter int BASE_ADDR = 1,
    parameter int MAX_WORDS = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              mem_ready,
    output logic              mem_execute,
    output logic [1:0]        mem_func,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    output logic              bus_select,
    output logic [ADDR_W-1:0] start_addr,
    output logic              traversal_execute,
    output logic              load_done,
    output logic              load_error
);

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    loader_state_t     state;
    logic [15:0]       count;
    logic [15:0]       word_cnt;
    logic [15:0]       next_cnt;
    logic [15:0]       hdr_n;
    logic              take;
    logic              pack_take;
    logic              pack_clear;
    logic              word_valid;
    logic [DATA_W-1:0] word;

    assign take       = byte_valid & byte_ready;
    assign pack_take  = take && state == S_COLLECT;
    assign pack_clear = take && state == S_HDR1;
    assign hdr_n      = {byte_data, count[7:0]};
    assign next_cnt   = word_cnt + 16'd1;

    mem_loader_byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pack_clear),
        .take       (pack_take),
        .byte_data  (byte_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // frame parsing, memory write handshake and hand-off, all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= S_IDLE;
            count             <= '0;
            word_cnt          <= '0;
            byte_ready        <= 1'b0;
            mem_execute       <= 1'b0;
            mem_func          <= '0;
            address           <= '0;
            write_data        <= '0;
            bus_select        <= 1'b1;
            start_addr        <= ADDR_W'(BASE_ADDR);
            traversal_execute <= 1'b0;
            load_done         <= 1'b0;
            load_error        <= 1'b0;
        end else begin
            mem_execute <= 1'b0;
            case (state)
                S_IDLE: if (mem_ready) begin
                    state      <= S_HDR0;
                    byte_ready <= 1'b1;
                end
                S_HDR0: if (take) begin
                    count[7:0] <= byte_data;
                    state      <= S_HDR1;
                end
                S_HDR1: if (take) begin
                    count[15:8] <= byte_data;
                    word_cnt    <= '0;
                    if (hdr_n == 16'd0) begin
                        state             <= S_DONE;
                        byte_ready        <= 1'b0;
                        bus_select        <= 1'b0;
                        load_done         <= 1'b1;
                        traversal_execute <= 1'b1;
                    end else if (hdr_n > MAX_N) begin
                        state      <= S_ERROR;
                        byte_ready <= 1'b0;
                        load_error <= 1'b1;
                    end else begin
                        state <= S_COLLECT;
                    end
                end
                S_COLLECT: if (word_valid) begin
                    state      <= S_WRITE;
                    byte_ready <= 1'b0;
                end
                S_WRITE: if (mem_ready) begin
                    mem_execute <= 1'b1;
                    mem_func    <= MEM_FUNC_WRITE;
                    address     <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt);
                    write_data  <= word;
                    state       <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: if (!mem_ready) state <= S_WAIT_DONE;
                S_WAIT_DONE: if (mem_ready) begin
                    word_cnt <= next_cnt;
                    if (next_cnt == count) begin
                        state             <= S_DONE;
                        bus_select        <= 1'b0;
                        load_done         <= 1'b1;
                        traversal_execute <= 1'b1;
                    end else begin
                        state      <= S_COLLECT;
                        byte_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed and randomized frames against a byte-stream image model
module tb_mem_loader;
    import mem_loader_pkg::*;

    logic        clk = 0;
    logic        rst = 0;
    logic [7:0]  byte_data = 0;
    logic        byte_valid = 0;
    logic        byte_ready;
    logic        mem_ready = 0;
    logic        mem_execute;
    logic [1:0]  mem_func;
    logic [15:0] address;
    logic [63:0] write_data;
    logic        bus_select;
    logic [15:0] start_addr;
    logic        traversal_execute;
    logic        load_done;
    logic        load_error;

    int total = 0, bad = 0;
    int cyc = 0, lat = 1, busy = 0;
    int strobes = 0, unstable = 0, bad_func = 0;
    int first_strobe = 0, rise_cyc = 0, te_cyc = 0, last_acc = 0;
    logic te_prev = 0;
    logic [15:0] cap_a;
    logic [63:0] cap_d;
    logic [63:0] ram [int];

    mem_loader dut (
        .clk(clk), .rst(rst), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .mem_ready(mem_ready), .mem_execute(mem_execute),
        .mem_func(mem_func), .address(address), .write_data(write_data),
        .bus_select(bus_select), .start_addr(start_addr),
        .traversal_execute(traversal_execute), .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // behavioural memory_unit: records writes, goes busy for lat cycles per strobe
    always @(negedge clk) begin
        if (mem_execute) begin
            strobes++;
            ram[int'(address)] = write_data;
            if (mem_func !== MEM_FUNC_WRITE || bus_select !== 1'b1) bad_func++;
            if (strobes == 1) first_strobe = cyc;
            cap_a = address;
            cap_d = write_data;
            busy = lat;
            mem_ready = 0;
        end else if (busy > 0) begin
            if (address !== cap_a || write_data !== cap_d) unstable++;
            busy--;
            if (busy == 0) begin
                mem_ready = 1;
                rise_cyc = cyc;
            end
        end else mem_ready = 1;
        if (traversal_execute && !te_prev) te_cyc = cyc;
        te_prev = traversal_execute;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_byte_ready"}, byte_ready, 0);
        check({tag, "_mem_execute"}, mem_execute, 0);
        check({tag, "_mem_func"}, mem_func, 0);
        check({tag, "_address"}, address, 0);
        check({tag, "_write_data"}, write_data, 0);
        check({tag, "_bus_select"}, bus_select, 1);
        check({tag, "_start_addr"}, start_addr, 1);
        check({tag, "_trav_exec"}, traversal_execute, 0);
        check({tag, "_load_done"}, load_done, 0);
        check({tag, "_load_error"}, load_error, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 0;
        byte_valid = 0;
        #1 check_reset_values(tag);
        @(negedge clk);
        rst = 1;
        strobes = 0;
        unstable = 0;
        bad_func = 0;
        first_strobe = 0;
        ram.delete();
    endtask

    // present a byte until the loader can take it; acceptance happens on the following rising edge
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit ok = 0;
        int k = 0;
        while (!ok && k < 300) begin
            @(negedge clk);
            byte_data = b;
            byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ok = byte_valid && byte_ready;
            k++;
        end
        if (ok) last_acc = cyc + 1;
        else check("send_timeout", ok, 1);
    endtask

    task automatic end_frame();
        @(negedge clk);
        byte_valid = 0;
    endtask

    task automatic wait_end(input string tag);
        int k = 0;
        while (!(load_done || load_error) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_finished"}, load_done | load_error, 1);
    endtask

    function automatic logic [63:0] model_word(input logic [7:0] fr[$], input int i);
        logic [63:0] w = 0;
        for (int j = 0; j < 8; j++) w[j*8 +: 8] = fr[2 + i*8 + j];
        return w;
    endfunction

    task automatic check_image(input string tag, input logic [7:0] fr[$], input int n);
        for (int i = 0; i < n; i++)
            check($sformatf("%s_ram%0d", tag, i + 1), ram.exists(i + 1) ? ram[i + 1] : 64'hx, model_word(fr, i));
        check({tag, "_strobes"}, strobes, n);
        check({tag, "_func"}, bad_func, 0);
        check({tag, "_stable"}, unstable, 0);
    endtask

    initial begin
        logic [7:0] fr[$];
        int n, acc8;

        // scenario 1: two words 01..10, fixed latency, byte offered during WRITE
        lat = 1;
        do_reset("rst1");
        fr = {8'd2, 8'd0};
        for (int i = 1; i <= 16; i++) fr.push_back(8'(i));
        acc8 = 0;
        for (int i = 0; i < fr.size(); i++) begin
            send_byte(fr[i], 0);
            if (i == 9) begin
                acc8 = last_acc;
                @(negedge clk);
                byte_data = fr[10];
                byte_valid = 1;
                check("ready_in_write", byte_ready, 0);
            end
        end
        end_frame();
        wait_end("s1");
        @(negedge clk);
        check_image("s1", fr, 2);
        check("s1_ram1_lit", ram[1], 64'h0807060504030201);
        check("s1_ram2_lit", ram[2], 64'h100F0E0D0C0B0A09);
        check("s1_first_strobe_lat", first_strobe - acc8, 1);
        check("s1_te_lat", te_cyc - rise_cyc, 1);
        check("s1_trav_exec", traversal_execute, 1);
        check("s1_start_addr", start_addr, 1);
        check("s1_bus_select", bus_select, 0);
        check("s1_load_done", load_done, 1);

        // scenario 2: empty image
        do_reset("rst2");
        send_byte(8'd0, 0);
        send_byte(8'd0, 0);
        end_frame();
        @(negedge clk);
        check("s2_done", load_done, 1);
        check("s2_trav_exec", traversal_execute, 1);
        check("s2_bus_select", bus_select, 0);
        repeat (4) @(negedge clk);
        check("s2_strobes", strobes, 0);

        // scenario 3: oversize header
        do_reset("rst3");
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        end_frame();
        repeat (3) @(negedge clk);
        check("s3_error", load_error, 1);
        check("s3_byte_ready", byte_ready, 0);
        check("s3_bus_select", bus_select, 1);
        check("s3_trav_exec", traversal_execute, 0);
        check("s3_strobes", strobes, 0);

        // scenario 3b: header at exactly the limit is accepted
        do_reset("rst3b");
        send_byte(8'hFF, 0);
        send_byte(8'h03, 0);
        end_frame();
        repeat (2) @(negedge clk);
        check("s3b_no_error", load_error, 0);
        check("s3b_collecting", byte_ready, 1);

        // scenario 4: same image, random valid gaps, slow memory
        lat = 5;
        do_reset("rst4");
        for (int i = 0; i < fr.size(); i++) send_byte(fr[i], 1);
        end_frame();
        wait_end("s4");
        check_image("s4", fr, 2);

        // scenario 5: reset midway through word 1, then a fresh one-word frame
        lat = 2;
        do_reset("rst5");
        fr = {8'd2, 8'd0};
        for (int i = 0; i < 16; i++) fr.push_back(8'($urandom));
        for (int i = 0; i < 13; i++) send_byte(fr[i], 0);
        @(negedge clk);
        rst = 0;
        byte_valid = 0;
        #1 check_reset_values("midrst");
        check("s5_word0_kept", ram[1], model_word(fr, 0));
        check("s5_strobes_before", strobes, 1);
        @(negedge clk);
        rst = 1;
        strobes = 0;
        unstable = 0;
        ram.delete();
        fr = {8'd1, 8'd0};
        for (int i = 0; i < 8; i++) fr.push_back(8'($urandom));
        for (int i = 0; i < fr.size(); i++) send_byte(fr[i], 1);
        end_frame();
        wait_end("s5");
        check_image("s5", fr, 1);

        // scenario 6: random frames
        for (int r = 0; r < 3; r++) begin
            lat = $urandom_range(1, 4);
            n = $urandom_range(1, 3);
            do_reset($sformatf("rst6_%0d", r));
            fr = {8'(n), 8'd0};
            for (int i = 0; i < n * 8; i++) fr.push_back(8'($urandom));
            for (int i = 0; i < fr.size(); i++) send_byte(fr[i], 1);
            end_frame();
            wait_end($sformatf("s6_%0d", r));
            check_image($sformatf("s6_%0d", r), fr, n);
            check($sformatf("s6_%0d_te", r), traversal_execute, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Front-end stage directly upstream of mem_traversal.
- Receives a byte stream from a host link, assembles memory words, and writes them into memory_unit at consecutive addresses.
- When the image is complete it asserts traversal_execute and start_addr to mem_traversal.
- Owns the memory bus through a select output until the image is loaded; after that the existing traversal/execute mux path takes over.

Parameters:
- ADDR_W, `memory_addr_width: memory address width.
- DATA_W, `memory_data_width: memory word width.
- BASE_ADDR, 1: first address written; also driven on start_addr.
- MAX_WORDS, 1023: largest accepted image, in words.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- byte_data  in  8  host byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_ready  in  1  memory_unit is_ready.
- mem_execute  out  1  memory request strobe.
- mem_func  out  2  memory function; always `MEM_FUNC_WRITE while loading.
- address  out  ADDR_W  write address.
- write_data  out  DATA_W  assembled word.
- bus_select  out  1  1 = loader drives the memory bus; 0 = traversal/execute mux drives it.
- start_addr  out  ADDR_W  root address handed to mem_traversal.
- traversal_execute  out  1  start level to mem_traversal.
- load_done  out  1  image written successfully.
- load_error  out  1  header count exceeded MAX_WORDS.

Behaviour:
- Reset values (rst low, asynchronous):
  - byte_ready=0, mem_execute=0, mem_func=0, address=0, write_data=0.
  - bus_select=1, start_addr=BASE_ADDR.
  - traversal_execute=0, load_done=0, load_error=0.
  - State machine goes to IDLE.
- Byte transfer: a byte is taken on any rising edge where byte_valid & byte_ready.
- Bytes per word: NB = ceil(DATA_W/8). Bytes are little-endian within a word. Bits of the last byte above DATA_W are discarded.
- Frame format: 2-byte word count N (low byte first), followed by N*NB payload bytes.
- State machine:
  - IDLE: byte_ready=0. Moves to HDR0 once mem_ready=1 (memory initialised after reset).
  - HDR0: byte_ready=1. On accept, latch count[7:0], go to HDR1.
  - HDR1: byte_ready=1. On accept, latch count[15:8].
    - If N=0: go to DONE.
    - If N>MAX_WORDS: go to ERROR.
    - Otherwise: clear word counter and byte index, go to COLLECT.
  - COLLECT: byte_ready=1. Each accepted byte is shifted into the word register at lane byte_idx. On the NB-th byte, go to WRITE.
  - WRITE: byte_ready=0. Waits for mem_ready=1, then drives mem_execute=1 for exactly one cycle with:
    - mem_func=`MEM_FUNC_WRITE
    - address=BASE_ADDR+word_cnt
    - write_data=word
    Then go to WAIT_BUSY.
  - WAIT_BUSY: waits for mem_ready=0, then go to WAIT_DONE.
  - WAIT_DONE: waits for mem_ready=1, then increments word_cnt.
    - If word_cnt==N: go to DONE.
    - Otherwise: go to COLLECT.
  - DONE: bus_select=0, load_done=1, traversal_execute=1. All three are held until reset.
  - ERROR: load_error=1, byte_ready=0, bus_select stays 1. Held until reset.
- Latency:
  - First write strobe occurs 1 cycle after the last byte of word 0 (when mem_ready=1).
  - traversal_execute rises 1 cycle after the final mem_ready rise.
- Timing rules:
  - address and write_data stay stable from WRITE until WAIT_DONE exits.
  - byte_valid may drop at any time in COLLECT without loss; the partial word is retained.
  - Bytes presented outside HDR0/HDR1/COLLECT are not accepted (byte_ready=0).
- Address arithmetic: BASE_ADDR+word_cnt is computed at ADDR_W bits. MAX_WORDS must satisfy BASE_ADDR+MAX_WORDS-1 < 2^ADDR_W, so the address never wraps.
- Reset mid-load: any in-progress word is discarded and mem_execute drops immediately. Memory contents already written are left untouched.

Decomposition:
- Shared constants, taken from memory_unit.vh:
  - `MEM_FUNC_WRITE (and the other memory function codes)
  - `memory_addr_width, `memory_data_width
- Loader state encodings go in a new loader.vh.
- Natural sub-module: byte_packer. It collects NB bytes into one DATA_W word and provides word_valid plus clear. The FSM and memory handshake stay in mem_loader.

Test Plan:
- DATA_W=64, N=2, sixteen bytes 01..10 -> ram[1]=0x0807060504030201, ram[2]=0x100F0E0D0C0B0A09; then traversal_execute=1, start_addr=1, bus_select=0.
- Header N=0 -> DONE within 2 cycles of the second header byte; no mem_execute pulse ever.
- Header N=1024 (MAX_WORDS=1023) -> load_error=1, byte_ready=0, no writes, traversal_execute stays 0.
- byte_valid toggled randomly and mem_ready held low for 5 cycles after each strobe -> same memory image as the first scenario; exactly one mem_execute pulse per word.
- rst asserted in COLLECT midway through word 1 -> all outputs at reset values the same cycle. A fresh N=1 frame then writes ram[1] correctly.
- Bytes offered while in WRITE/WAIT_BUSY -> byte_ready=0; byte not consumed and appears in the next word.
